// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the multiply/divide unit.
//   - MDU op encodings as presented on the op field
//   - FSM state encoding of the iterative multiply/divide engine
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle between the control/register-file side and the multiply/divide unit.
//   start, op, a, b    : operation launch (start sampled only while idle)
//   we_hi, we_lo, wd   : MTHI/MTLO writes (honoured only while idle)
//   hi, lo             : architectural HI/LO contents (registered)
//   busy, done         : stall request and one-cycle completion pulse
// Handshake: start is a single-cycle request with no ready; it is accepted
// exactly when busy is low at the sampling edge and silently dropped
// otherwise. done is a one-cycle strobe with no back-pressure.
// modport master = control side, modport slave = mult_div_unit.
interface mult_div_unit_if #(
  parameter int data_width = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [data_width-1:0] a;
  logic [data_width-1:0] b;
  logic                  we_hi;
  logic                  we_lo;
  logic [data_width-1:0] wd;
  logic [data_width-1:0] hi;
  logic [data_width-1:0] lo;
  logic                  busy;
  logic                  done;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the MIPS HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per clock on
// operand magnitudes, followed by a sign-fix cycle that writes HI/LO.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          mult_div_unit_if.slave (operands, MTHI/MTLO, HI/LO, busy/done)
//   dbg_state_o  current FSM state, for observation only
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_div_unit_if.slave         bus,
  output mdu_state_e             dbg_state_o
);

  localparam int W  = data_width;
  localparam int CW = $clog2(data_width);
  localparam logic [CW-1:0] CNT_LAST = CW'(data_width - 1);

  mdu_state_e     state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           sign_a_q, sign_a_d;
  logic           sign_b_q, sign_b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Shared working register: multiply {partial product, multiplier},
  // divide {partial remainder, dividend/quotient}.
  logic [2*W-1:0] work_q, work_d;
  // Multiplicand magnitude for multiplies, divisor magnitude for divides.
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  // Launch-time decode of the incoming operation.
  logic           in_signed, in_mult;
  logic [W-1:0]   mag_a, mag_b;

  // One iteration of each algorithm.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_shift;
  logic [W-1:0]   div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;

  // Sign-fix results.
  logic           q_is_mult;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  always_comb begin
    in_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    in_mult   = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
    mag_a     = (in_signed && bus.a[W-1]) ? (~bus.a + 1'b1) : bus.a;
    mag_b     = (in_signed && bus.b[W-1]) ? (~bus.b + 1'b1) : bus.b;
  end

  always_comb begin
    // Shift-add: the carry out of the add becomes the new top bit.
    mul_sum  = {1'b0, work_q[2*W-1:W]} + {1'b0, opnd_q};
    mul_next = work_q[0] ? {mul_sum, work_q[W-1:1]}
                         : {1'b0, work_q[2*W-1:W], work_q[W-1:1]};
    // Restoring divide: the shifted remainder needs W+1 bits; when it is at
    // least the divisor the difference always fits back in W bits.
    rem_shift = {work_q[2*W-1:W], work_q[W-1]};
    div_ge    = rem_shift >= {1'b0, opnd_q};
    div_diff  = rem_shift[W-1:0] - opnd_q;
    div_next  = div_ge ? {div_diff, work_q[W-2:0], 1'b1}
                       : {rem_shift[W-1:0], work_q[W-2:0], 1'b0};
  end

  always_comb begin
    q_is_mult = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
    prod_fix  = ((op_q == MDU_MULT) && (sign_a_q != sign_b_q))
                ? (~work_q + 1'b1) : work_q;
    quot_fix  = ((op_q == MDU_DIV) && (sign_a_q != sign_b_q))
                ? (~work_q[W-1:0] + 1'b1) : work_q[W-1:0];
    // Remainder follows the dividend's sign.
    rem_fix   = ((op_q == MDU_DIV) && sign_a_q)
                ? (~work_q[2*W-1:W] + 1'b1) : work_q[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      MDU_IDLE: begin
        if (bus.we_hi) hi_d = bus.wd;
        if (bus.we_lo) lo_d = bus.wd;
        if (bus.start) begin
          state_d  = MDU_CALC;
          op_d     = bus.op;
          sign_a_d = bus.a[W-1];
          sign_b_d = bus.b[W-1];
          cnt_d    = '0;
          if (in_mult) begin
            work_d = {{W{1'b0}}, mag_b};
            opnd_d = mag_a;
          end else begin
            work_d = {{W{1'b0}}, mag_a};
            opnd_d = mag_b;
          end
        end
      end
      MDU_CALC: begin
        work_d = q_is_mult ? mul_next : div_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        if (q_is_mult) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      op_q     <= MDU_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = (state_q != MDU_IDLE);
  assign bus.done    = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of operations with
// hand-computed HI/LO results, plus sequences for back-to-back issue,
// ignored requests while busy, MTLO, start+MTHI, and reset mid-operation.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  mdu_state_e dbg_state;

  always #5 clk = ~clk;

  mult_div_unit_if #(.data_width(W)) bus ();

  mult_div_unit #(.data_width(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
  endtask

  // Counts busy cycles up to and including the current negedge; returns on
  // the negedge where done is high, or after a bounded number of cycles.
  task automatic wait_done(output int bc, output bit seen);
    bc   = 0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy) bc++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string name, input logic [1:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] eh, input logic [W-1:0] el);
    int bc;
    bit seen;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    launch(op, a, b);
    wait_done(bc, seen);
    check({name, "_done"}, W'(seen), 32'd1);
    check({name, "_busy_cycles"}, W'(bc), 32'd33);
    check({name, "_hi"}, bus.hi, exp_q.pop_front());
    check({name, "_lo"}, bus.lo, exp_q.pop_front());
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin : main
    int  bc;
    bit  seen;
    int  dn;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{MDU_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[6]  = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001};
    vecs[9]  = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[10] = '{MDU_MULT,  32'h12345678, 32'd0,        32'h00000000, 32'h00000000};
    vecs[11] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    vecs[12] = '{MDU_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
    vecs[13] = '{MDU_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};

    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    bus.wd    = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", W'(bus.busy), 32'h0);
    check("rst_done", W'(bus.done), 32'h0);
    check("rst_state", W'(dbg_state), W'(MDU_IDLE));

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp_hi, vecs[i].exp_lo);
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), W'(bus.done), 32'h0);
    end

    // Back-to-back: second op issued on the done cycle of the first
    run_and_check("b2b_mult", MDU_MULT, 32'hFFFFFFFD, 32'd5,
                  32'hFFFFFFFF, 32'hFFFFFFF1);
    run_and_check("b2b_div", MDU_DIV, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFF, 32'hFFFFFFFD);
    @(negedge clk);

    // start and MTHI while busy are ignored; HI/LO hold until FIX
    launch(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bc   = 0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy) bc++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (k == 5) begin
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.we_hi = 1'b1;
        bus.wd    = 32'h1234;
      end
      if (k == 6) begin
        bus.start = 1'b0;
        bus.we_hi = 1'b0;
      end
      if (k == 10) begin
        check("busy_hold_hi", bus.hi, 32'hFFFFFFFF);
        check("busy_hold_lo", bus.lo, 32'hFFFFFFFD);
      end
      @(negedge clk);
    end
    check("ign_done", W'(seen), 32'd1);
    check("ign_busy_cycles", W'(bc), 32'd33);
    check("ign_hi", bus.hi, 32'hFFFFFFFE);
    check("ign_lo", bus.lo, 32'h00000001);
    @(negedge clk);
    check("ign_no_second_done", W'(bus.done), 32'h0);
    check("ign_idle", W'(bus.busy), 32'h0);

    // MTLO in idle
    bus.we_lo = 1'b1;
    bus.wd    = 32'hCAFEF00D;
    @(negedge clk);
    bus.we_lo = 1'b0;
    check("mtlo_lo", bus.lo, 32'hCAFEF00D);
    check("mtlo_hi", bus.hi, 32'hFFFFFFFE);

    // start together with MTHI: write lands now, result overwrites it
    bus.we_hi = 1'b1;
    bus.wd    = 32'h0000AAAA;
    launch(MDU_MULTU, 32'h12345678, 32'h10);
    check("st_we_hi", bus.hi, 32'h0000AAAA);
    check("st_we_lo", bus.lo, 32'hCAFEF00D);
    wait_done(bc, seen);
    check("st_we_done", W'(seen), 32'd1);
    check("st_we_res_hi", bus.hi, 32'h00000001);
    check("st_we_res_lo", bus.lo, 32'h23456780);
    @(negedge clk);

    // Reset 10 cycles into a MULTU
    launch(MDU_MULTU, 32'h00010000, 32'h00010000);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", W'(bus.busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_hi", bus.hi, 32'h0);
    check("mid_rst_lo", bus.lo, 32'h0);
    check("mid_rst_busy", W'(bus.busy), 32'h0);
    check("mid_rst_state", W'(dbg_state), W'(MDU_IDLE));
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    check("mid_rst_no_done", W'(dn), 32'h0);
    check("mid_rst_hi_after", bus.hi, 32'h0);

    // Report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and consumes its RD1/RD2 read ports as operands for MULT, MULTU, DIV and DIVU. It holds the architectural HI/LO registers that MFHI/MFLO read back and MTHI/MTLO write. It runs one shift-add or restoring-subtract step per clock and raises `busy` so the control unit can stall.

## Interface
- `data_width`, 32: operand and HI/LO width; iteration count equals `data_width`
- `clk`  in  1  rising-edge clock; the only clock
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  launch operation `op`; sampled only when idle
- `op`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- `a`  in  data_width  operand (from RD1): multiplicand/dividend
- `b`  in  data_width  operand (from RD2): multiplier/divisor
- `we_hi`, `we_lo`  in  1 each  MTHI/MTLO write enables
- `wd`  in  data_width  MTHI/MTLO write data
- `hi`, `lo`  out  data_width  HI/LO register contents; registered
- `busy`  out  1  operation in progress; control stalls while high
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- FSM states:
  - IDLE -> CALC on `start`. Latch `op`. Latch |a| and |b| for signed ops, raw values for unsigned ops. Latch both operand signs. Clear the counter.
  - CALC runs one iteration per edge. On the edge where counter = data_width-1, go to FIX.
  - FIX applies the sign correction, writes `hi`/`lo`, pulses `done`, then returns to IDLE.
- Multiply is unsigned shift-add on magnitudes, producing a 2·data_width product. For MULT, negate the product when the operand signs differ. HI = upper half, LO = lower half.
- Divide is unsigned restoring division on magnitudes. For DIV, negate the quotient when the signs differ; the remainder takes the dividend's sign. LO = quotient, HI = remainder.
- Divide by zero uses the raw algorithm result, with no trap:
  - DIVU: LO=all-ones, HI=a.
  - DIV: HI=a; LO=all-ones if a≥0, else 1.
- DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0, with no overflow flag.
- Arithmetic width rules: magnitudes are data_width bits unsigned. The divide partial remainder is data_width+1 bits. All negation is two's complement modulo the field width.
- `we_hi`/`we_lo` write `wd` on the clock edge only when IDLE. They are ignored while busy.
- `start` while busy is ignored, with no queueing.
- `start` together with `we_hi`/`we_lo` in IDLE: the write lands now, and the operation's result overwrites it at FIX.
- `rst` mid-operation abandons the operation and returns everything to its reset values. `done` does not pulse.

## Timing
- `start` sampled at edge E. `busy`=1 in the cycles after edges E..E+data_width, which is data_width+1 cycles.
- FIX executes at edge E+data_width+1. In the following cycle, `hi`/`lo` hold the result, `done`=1 and `busy`=0.
- Total latency is data_width+2 edges, 34 for the default.
- A new `start` is accepted in the same cycle that `done` is high, so back-to-back issue is possible.
- `hi`/`lo` do not change during CALC. Reads while busy return the previous values.
- MTHI/MTLO take effect after one edge, so `hi`/`lo` show `wd` in the next cycle.

## Structure
- Shared package `mips_pkg`:
  - op encoding constants (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`)
  - FSM state encoding (IDLE, CALC, FIX)
- No sub-module. The FSM, counter and shared accumulator/shift register form one module.
- The multiply and divide paths share the 2·data_width working register.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 cycles: `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulses once.
- MULT a=0xFFFFFFFD (-3), b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7), b=2, issued back-to-back on the `done` cycle -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=100, b=0 -> `lo`=0xFFFFFFFF, `hi`=0x00000064. DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- While busy: assert `start` with different operands, plus `we_hi`=1 with `wd`=0x1234 -> both ignored. Result matches the first operation, and `busy` stays high exactly 33 cycles.
- In IDLE: `we_lo`=1, `wd`=0xCAFEF00D -> `lo`=0xCAFEF00D next cycle and `hi` unchanged.
- Assert `rst` 10 cycles into a MULTU -> next cycle `hi`=`lo`=0, `busy`=0, and no `done` pulse afterwards.
